apb_spi_regif: RTL

Parametrised APB3 register front-end for the SPI controller: decodes the APB bus, holds control and baud registers, and buffers transmit and receive frames in independent FIFOs. It feeds the SPI shifter through a valid/ready TX port and accepts frames from it on an RX port. It also generates the run/wait/stop mode, the status flags and the interrupt. Successor to the single-byte, unbuffered register interface, with a configurable frame width, configurable FIFO depths, error responses and sticky flags.

---
 rtl/spi_pkg.sv | 55 +++++
 rtl/spi_sync_fifo.sv | 48 ++++
 rtl/apb_spi_regif.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the APB SPI register front-end: register indices,
// write masks, status bit positions, CR1 layout and the run/wait/stop mode.
package spi_pkg;

  localparam logic [2:0] REG_CR1 = 3'd0;
  localparam logic [2:0] REG_CR2 = 3'd1;
  localparam logic [2:0] REG_BR  = 3'd2;
  localparam logic [2:0] REG_SR  = 3'd3;
  localparam logic [2:0] REG_DR  = 3'd4;
  localparam logic [2:0] REG_LVL = 3'd5;

  localparam logic [7:0] CR1_RESET = 8'h04;
  localparam logic [7:0] CR2_MASK  = 8'h1B;
  localparam logic [7:0] BR_MASK   = 8'h77;

  localparam int unsigned CR2_MODFEN_BIT  = 4;
  localparam int unsigned CR2_SPISWAI_BIT = 1;

  localparam int unsigned SR_SPIF_BIT   = 7;
  localparam int unsigned SR_SPTEF_BIT  = 5;
  localparam int unsigned SR_MODF_BIT   = 4;
  localparam int unsigned SR_OVR_BIT    = 3;
  localparam int unsigned SR_TXFULL_BIT = 2;
  localparam int unsigned SR_RXFULL_BIT = 1;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_WAIT = 2'b01,
    MODE_STOP = 2'b10
  } spi_mode_t;

  typedef struct packed {
    logic spie;
    logic spe;
    logic sptie;
    logic mstr;
    logic cpol;
    logic cpha;
    logic ssoe;
    logic lsbfe;
  } cr1_t;

  // Enable bit dominates; with the controller disabled spiswai picks stop vs wait.
  function automatic spi_mode_t mode_target(input logic spe, input logic spiswai);
    spi_mode_t m;
    m = MODE_WAIT;
    if (spe) begin
      m = MODE_RUN;
    end else if (spiswai) begin
      m = MODE_STOP;
    end
    return m;
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with a fall-through head; pointers carry one extra wrap bit
// so full and empty are distinguished by the pointer difference.
module spi_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == PW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO only lands if the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/apb_spi_regif.sv
// APB3 register front-end of the SPI controller: config registers, TX/RX frame
// FIFOs, sticky fault flags, run/wait/stop mode and the registered interrupt.
module apb_spi_regif
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [4:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tip,
  input  logic              ss_in,
  output logic              mstr,
  output logic              cpol,
  output logic              cpha,
  output logic              lsbfe,
  output logic              spiswai,
  output logic [2:0]        sppr,
  output logic [2:0]        spr,
  output logic [1:0]        spi_mode,
  output logic              irq
);

  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

  cr1_t       cr1_q, cr1_d;
  logic [7:0] cr2_q, cr2_d;
  logic [7:0] br_q, br_d;
  logic       modf_q, modf_d;
  logic       ovr_q, ovr_d;
  logic       irq_q, irq_d;
  spi_mode_t  mode_q;

  logic             acc, err_c, wr_ok, rd_ok, dr_pop, rx_run;
  logic             modf_set, ovr_set;
  logic [2:0]       idx;
  logic [31:0]      rdata_c;
  logic [7:0]       sr_c;

  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [TX_CW-1:0]  tx_cnt;
  logic              rx_push, rx_full, rx_empty;
  logic [RX_CW-1:0]  rx_cnt;
  logic [DATA_W-1:0] rx_head;

  logic unused_bits;
  assign unused_bits = ^{PADDR, PWDATA};

  assign acc = PSEL & PENABLE;
  assign idx = PADDR[4:2];

  // Access-phase error decode; a flagged access never changes any state.
  always_comb begin
    err_c = 1'b0;
    case (idx)
      REG_CR1, REG_BR: err_c = PWRITE & tip;
      REG_CR2, REG_SR: err_c = 1'b0;
      REG_DR:          err_c = PWRITE ? tx_full : rx_empty;
      REG_LVL:         err_c = PWRITE;
      default:         err_c = 1'b1;
    endcase
  end

  assign wr_ok  = acc & PWRITE & ~err_c;
  assign rd_ok  = acc & ~PWRITE & ~err_c;
  assign dr_pop = rd_ok & (idx == REG_DR);

  assign tx_push  = wr_ok & (idx == REG_DR);
  assign tx_valid = ~tx_empty & (mode_q != MODE_STOP);
  assign tx_pop   = tx_valid & tx_ready;

  // Frames are dropped silently in STOP; a full FIFO only overruns outside STOP.
  assign rx_run   = (mode_q != MODE_STOP);
  assign rx_push  = rx_valid & rx_run & (~rx_full | dr_pop);
  assign ovr_set  = rx_valid & rx_run & rx_full & ~dr_pop;
  assign modf_set = ~ss_in & cr1_q.mstr & cr2_q[CR2_MODFEN_BIT] & ~cr1_q.ssoe;

  spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (PWDATA[DATA_W-1:0]),
    .rdata_o (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_cnt)
  );

  spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .push_i  (rx_push),
    .pop_i   (dr_pop),
    .wdata_i (rx_data),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_cnt)
  );

  // Register next state; hardware sets are applied last so they beat W1C.
  always_comb begin
    cr1_d  = cr1_q;
    cr2_d  = cr2_q;
    br_d   = br_q;
    modf_d = modf_q;
    ovr_d  = ovr_q;
    if (wr_ok) begin
      case (idx)
        REG_CR1: cr1_d = cr1_t'(PWDATA[7:0]);
        REG_CR2: cr2_d = PWDATA[7:0] & CR2_MASK;
        REG_BR:  br_d  = PWDATA[7:0] & BR_MASK;
        REG_SR: begin
          if (PWDATA[SR_MODF_BIT]) modf_d = 1'b0;
          if (PWDATA[SR_OVR_BIT])  ovr_d  = 1'b0;
        end
        default: ;
      endcase
    end
    if (modf_set) begin
      modf_d     = 1'b1;
      cr1_d.mstr = 1'b0;
    end
    if (ovr_set) ovr_d = 1'b1;
  end

  assign irq_d = (cr1_q.spie & (~rx_empty | modf_q | ovr_q)) | (cr1_q.sptie & tx_empty);

  always_comb begin
    sr_c                = '0;
    sr_c[SR_SPIF_BIT]   = ~rx_empty;
    sr_c[SR_SPTEF_BIT]  = tx_empty;
    sr_c[SR_MODF_BIT]   = modf_q;
    sr_c[SR_OVR_BIT]    = ovr_q;
    sr_c[SR_TXFULL_BIT] = tx_full;
    sr_c[SR_RXFULL_BIT] = rx_full;
  end

  always_comb begin
    rdata_c = '0;
    case (idx)
      REG_CR1: rdata_c[7:0]        = cr1_q;
      REG_CR2: rdata_c[7:0]        = cr2_q;
      REG_BR:  rdata_c[7:0]        = br_q;
      REG_SR:  rdata_c[7:0]        = sr_c;
      REG_DR:  rdata_c[DATA_W-1:0] = rx_head;
      REG_LVL: rdata_c[15:0]       = {8'(rx_cnt), 8'(tx_cnt)};
      default: ;
    endcase
  end

  assign PREADY  = acc;
  assign PSLVERR = acc & err_c;
  assign PRDATA  = rd_ok ? rdata_c : 32'h0;

  // Registers and the mode FSM; mode follows CR1/CR2 with one cycle of lag.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cr1_q  <= cr1_t'(CR1_RESET);
      cr2_q  <= '0;
      br_q   <= '0;
      modf_q <= 1'b0;
      ovr_q  <= 1'b0;
      irq_q  <= 1'b0;
      mode_q <= MODE_RUN;
    end else begin
      cr1_q  <= cr1_d;
      cr2_q  <= cr2_d;
      br_q   <= br_d;
      modf_q <= modf_d;
      ovr_q  <= ovr_d;
      irq_q  <= irq_d;
      mode_q <= mode_target(cr1_q.spe, cr2_q[CR2_SPISWAI_BIT]);
    end
  end

  assign mstr     = cr1_q.mstr;
  assign cpol     = cr1_q.cpol;
  assign cpha     = cr1_q.cpha;
  assign lsbfe    = cr1_q.lsbfe;
  assign spiswai  = cr2_q[CR2_SPISWAI_BIT];
  assign sppr     = br_q[6:4];
  assign spr      = br_q[2:0];
  assign spi_mode = mode_q;
  assign irq      = irq_q;

endmodule
